// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared state/error encodings and the default frame marker
package uart_frame_pkg;

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, DRAIN} state_e;

    typedef enum logic [1:0] {ERR_NONE, ERR_CSUM, ERR_LEN, ERR_TIMEOUT} err_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'h55;

endpackage

// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if: byte input, payload stream and frame status of the frame parser
interface uart_frame_rx_if;

    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_last;
    logic [7:0]  o_len;
    logic        o_good;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic        o_overrun;
    logic [15:0] o_frame_count;

    modport master (
        output i_data, i_valid, i_ready,
        input  o_data, o_valid, o_last, o_len, o_good, o_err, o_err_code, o_overrun, o_frame_count
    );

    modport slave (
        input  i_data, i_valid, i_ready,
        output o_data, o_valid, o_last, o_len, o_good, o_err, o_err_code, o_overrun, o_frame_count
    );

endinterface

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload byte store, one write port and one asynchronous read port
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // capture payload bytes; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: parses SYNC/LEN/payload/CSUM frames and releases checked payload on a stream
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 120
) (
    input logic            clk,
    input logic            rst,
    uart_frame_rx_if.slave bus
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state, state_nx;
    err_e          err_code;
    logic [7:0]    len, sum;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [TW-1:0] timer;
    logic          in_frame, timeout, len_bad, csum_ok, wr_last, rd_last, wr_en;
    logic          err_fire, good_fire;

    assign in_frame = state inside {LEN, PAYLOAD, CSUM};
    assign timeout  = in_frame && !bus.i_valid && timer == TW'(TIMEOUT_CYCLES - 1);
    assign len_bad  = bus.i_data > 8'(MAX_LEN);
    assign csum_ok  = bus.i_data == sum;
    assign wr_last  = 8'(wr_idx) == len - 8'd1;
    assign rd_last  = 8'(rd_idx) == len - 8'd1;
    assign wr_en    = state == PAYLOAD && bus.i_valid;

    assign bus.o_valid = state == DRAIN;
    assign bus.o_last  = bus.o_valid && rd_last;

    uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_idx),
        .wdata (bus.i_data),
        .raddr (rd_idx),
        .rdata (bus.o_data)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // frame sequencing and detection of good/bad frames; a stall overrides everything
    always_comb begin
        state_nx  = state;
        err_fire  = 1'b0;
        err_code  = ERR_NONE;
        good_fire = 1'b0;
        case (state)
            IDLE:    if (bus.i_valid && bus.i_data == SYNC_BYTE) state_nx = LEN;
            LEN:     if (bus.i_valid) begin
                         state_nx = len_bad ? IDLE : (bus.i_data == 8'd0 ? CSUM : PAYLOAD);
                         err_fire = len_bad;
                         err_code = len_bad ? ERR_LEN : ERR_NONE;
                     end
            PAYLOAD: if (bus.i_valid && wr_last) state_nx = CSUM;
            CSUM:    if (bus.i_valid) begin
                         state_nx  = (csum_ok && len != 8'd0) ? DRAIN : IDLE;
                         good_fire = csum_ok;
                         err_fire  = !csum_ok;
                         err_code  = csum_ok ? ERR_NONE : ERR_CSUM;
                     end
            DRAIN:   if (bus.i_ready && rd_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (timeout) begin
            state_nx = IDLE;
            err_fire = 1'b1;
            err_code = ERR_TIMEOUT;
        end
    end

    // running sum, indices, idle timer and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            len               <= '0;
            sum               <= '0;
            wr_idx            <= '0;
            rd_idx            <= '0;
            timer             <= '0;
            bus.o_len         <= '0;
            bus.o_good        <= 1'b0;
            bus.o_err         <= 1'b0;
            bus.o_err_code    <= ERR_NONE;
            bus.o_overrun     <= 1'b0;
            bus.o_frame_count <= '0;
        end else begin
            bus.o_good    <= good_fire;
            bus.o_err     <= err_fire;
            bus.o_overrun <= state == DRAIN && bus.i_valid;
            timer         <= (in_frame && !bus.i_valid && !timeout) ? timer + 1'b1 : '0;
            if (err_fire) bus.o_err_code <= err_code;
            if (state == LEN && bus.i_valid) begin
                len    <= bus.i_data;
                sum    <= bus.i_data;
                wr_idx <= '0;
            end
            if (wr_en) begin
                sum    <= sum + bus.i_data;
                wr_idx <= wr_idx + 1'b1;
            end
            if (good_fire) begin
                bus.o_len         <= len;
                bus.o_frame_count <= bus.o_frame_count + 16'd1;
                rd_idx            <= '0;
            end
            if (state == DRAIN && bus.i_ready) rd_idx <= rd_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: randomized frame traffic checked against a frame-level outcome model
module tb_uart_frame_rx;

    localparam int         MAX_LEN = 16;
    localparam int         TO      = 120;
    localparam logic [7:0] SYNC    = 8'h55;
    localparam int K_GOOD = 0, K_BAD = 1, K_LONG = 2, K_STALL = 3;

    typedef logic [7:0] byte_q_t [$];

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_frame_rx_if bus();

    uart_frame_rx #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    int          pi = 0;
    logic [3:0]  ready_pat = 4'b1001;
    int          good_n, err_n, ovr_n, err_cyc, good_cyc, strobe_cyc;
    logic [1:0]  err_code_seen;
    logic        good_with_valid;
    logic [7:0]  out_q [$];
    logic        last_q [$];
    logic        stall_prev = 1'b0;
    logic [7:0]  data_prev;
    logic [15:0] exp_count = '0;
    logic [7:0]  exp_len = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // downstream readiness patterns
    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = 1'($urandom_range(0, 1));
                2:       begin bus.i_ready = ready_pat[pi % 4]; pi++; end
                default: bus.i_ready = 1'b0;
            endcase
        end
    end

    // event monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_good) begin good_n++; good_cyc = cyc; good_with_valid = bus.o_valid; end
            if (bus.o_err) begin err_n++; err_cyc = cyc; err_code_seen = bus.o_err_code; end
            if (bus.o_overrun) ovr_n++;
            if (stall_prev) begin
                check("hold_valid", 32'(bus.o_valid), 1);
                check("hold_data", 32'(bus.o_data), 32'(data_prev));
            end
            if (bus.o_valid && bus.i_ready) begin
                out_q.push_back(bus.o_data);
                last_q.push_back(bus.o_last);
            end
            stall_prev = bus.o_valid && !bus.i_ready;
            data_prev  = bus.o_data;
        end else stall_prev = 1'b0;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_data  = b;
        bus.i_valid = 1'b1;
        strobe_cyc  = cyc;
        idle(1);
        bus.i_valid = 1'b0;
        bus.i_data  = 8'($urandom);
    endtask

    task automatic clear_mon();
        good_n = 0; err_n = 0; ovr_n = 0; err_cyc = -1; good_cyc = -1;
        out_q.delete();
        last_q.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        idle(2);
        while (bus.o_valid && n < 3000) begin idle(1); n++; end
        if (n >= 3000) check("drain_bound", 1, 0);
        idle(2);
    endtask

    // drive one frame and compare every observed outcome with what the frame rules predict
    task automatic do_frame(input int kind, input int lenf, input byte_q_t pl, input int gap, input bit inject);
        logic [7:0] s, b;
        int t, cut;
        clear_mon();
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            send_byte(b);
            idle(gap);
        end
        send_byte(SYNC);
        idle(gap);
        send_byte(8'(lenf));
        t = strobe_cyc;
        if (kind == K_LONG) begin
            idle(4);
            check("len_err_code", 32'(err_code_seen), 2);
            check("len_err_at", err_cyc - t, 1);
        end else begin
            s   = 8'(lenf);
            cut = (kind == K_STALL) ? $urandom_range(0, pl.size()) : pl.size();
            for (int i = 0; i < cut; i++) begin
                idle(gap);
                send_byte(pl[i]);
                s = s + pl[i];
                t = strobe_cyc;
            end
            if (kind == K_STALL) begin
                idle(TO + 4);
                check("to_code", 32'(err_code_seen), 3);
                check("to_at", err_cyc - t, TO + 1);
            end else begin
                idle(gap);
                send_byte(kind == K_BAD ? s + 8'($urandom_range(1, 255)) : s);
                t = strobe_cyc;
                if (inject) send_byte(SYNC);
                wait_idle();
                if (kind == K_GOOD) begin
                    exp_count = exp_count + 16'd1;
                    exp_len   = 8'(lenf);
                    check("good_at", good_cyc - t, 1);
                    check("good_valid", 32'(good_with_valid), 32'(lenf > 0));
                    for (int i = 0; i < pl.size() && i < out_q.size(); i++) begin
                        check("data", 32'(out_q[i]), 32'(pl[i]));
                        check("last", 32'(last_q[i]), 32'(i == pl.size() - 1));
                    end
                end else begin
                    check("csum_code", 32'(err_code_seen), 1);
                    check("csum_at", err_cyc - t, 1);
                end
            end
        end
        check("err_n", err_n, kind == K_GOOD ? 0 : 1);
        check("good_n", good_n, 32'(kind == K_GOOD));
        check("out_n", out_q.size(), kind == K_GOOD ? pl.size() : 0);
        check("overrun", ovr_n, 32'(inject));
        check("count", 32'(bus.o_frame_count), 32'(exp_count));
        check("o_len", 32'(bus.o_len), 32'(exp_len));
    endtask

    function automatic byte_q_t rand_payload(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom));
        return q;
    endfunction

    initial begin
        byte_q_t pl;
        int kind, n;
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b0;
        idle(4);
        check("rst_valid", 32'(bus.o_valid), 0);
        check("rst_last", 32'(bus.o_last), 0);
        check("rst_good", 32'(bus.o_good), 0);
        check("rst_err", 32'(bus.o_err), 0);
        check("rst_code", 32'(bus.o_err_code), 0);
        check("rst_len", 32'(bus.o_len), 0);
        check("rst_ovr", 32'(bus.o_overrun), 0);
        check("rst_count", 32'(bus.o_frame_count), 0);
        rst = 1'b0;
        idle(2);

        pl = '{8'h11, 8'h22, 8'h33};
        do_frame(K_GOOD, 3, pl, 0, 1'b0);
        do_frame(K_BAD, 3, pl, 0, 1'b0);
        do_frame(K_LONG, 8'h14, pl, 0, 1'b0);
        pl = '{8'hAA};
        do_frame(K_GOOD, 1, pl, 0, 1'b0);
        pl = '{8'h10, 8'h20};
        do_frame(K_STALL, 2, pl, 0, 1'b0);
        pl.delete();
        do_frame(K_GOOD, 0, pl, 0, 1'b0);
        do_frame(K_GOOD, MAX_LEN, rand_payload(MAX_LEN), 0, 1'b0);
        do_frame(K_LONG, MAX_LEN + 1, pl, 0, 1'b0);
        do_frame(K_GOOD, 2, rand_payload(2), TO - 1, 1'b0);
        ready_mode = 2;
        do_frame(K_GOOD, 4, rand_payload(4), 0, 1'b1);
        ready_mode = 0;

        clear_mon();
        send_byte(SYNC); send_byte(8'h03); send_byte(8'h11);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_count = '0;
        idle(TO + 10);
        check("rst_mid_err", err_n, 0);
        check("rst_mid_count", 32'(bus.o_frame_count), 0);
        pl = '{8'h7F};
        do_frame(K_GOOD, 1, pl, 0, 1'b0);

        ready_mode = 3;
        send_byte(SYNC); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h05);
        idle(3);
        check("drain_stall", 32'(bus.o_valid), 1);
        rst = 1'b1;
        idle(1);
        check("drain_rst_valid", 32'(bus.o_valid), 0);
        check("drain_rst_err", 32'(bus.o_err), 0);
        rst = 1'b0;
        ready_mode = 0;
        exp_count = '0;
        exp_len   = '0;
        idle(2);

        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 3);
            n    = $urandom_range(0, MAX_LEN);
            ready_mode = $urandom_range(0, 2);
            do_frame(kind, kind == K_LONG ? $urandom_range(MAX_LEN + 1, 255) : n, rand_payload(n),
                     $urandom_range(0, 3), kind == K_GOOD && n > 0 && $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
